// File: rtl/board_turn_ctrl.sv
// Tic-tac-toe board controller: takes square clicks, alternates turns, runs a
// one-line-per-cycle win/draw check and drives per-square enables and colours.
module board_turn_ctrl #(
  parameter logic [11:0] X_COLOR      = 12'hF00,
  parameter logic [11:0] O_COLOR      = 12'h00F,
  parameter logic [11:0] WIN_COLOR    = 12'h0F0,
  parameter logic        FIRST_PLAYER = 1'b0
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start_en,
  input  logic         choice_en,
  input  logic         click,
  input  logic [3:0]   click_sq,
  input  logic         new_game,
  output logic [8:0]   square_en,
  output logic [107:0] square_color,
  output logic         turn,
  output logic         busy,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [3:0]   move_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_CLICK, CHECK, OVER} state_t;

  state_t       state, state_n;
  logic [8:0]   board_x, board_x_n;
  logic [8:0]   board_o, board_o_n;
  logic [8:0]   win_line, win_line_n;
  logic [2:0]   line_idx, line_idx_n;
  logic         turn_n;
  logic [1:0]   winner_n;
  logic [3:0]   move_cnt_n;
  logic [107:0] color_n;
  logic [8:0]   sq_mask;
  logic [8:0]   mover_board;
  logic [8:0]   cur_line;

  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    line_mask = 9'b000_000_111;
      3'd1:    line_mask = 9'b000_111_000;
      3'd2:    line_mask = 9'b111_000_000;
      3'd3:    line_mask = 9'b001_001_001;
      3'd4:    line_mask = 9'b010_010_010;
      3'd5:    line_mask = 9'b100_100_100;
      3'd6:    line_mask = 9'b100_010_001;
      default: line_mask = 9'b001_010_100;
    endcase
  endfunction

  function automatic logic [107:0] color_mux(input logic [8:0] bx, input logic [8:0] bo,
                                             input logic [8:0] wl, input logic over);
    logic [107:0] c;
    c = '0;
    for (int k = 0; k < 9; k++) begin
      if (over && wl[k])  c[12*k +: 12] = WIN_COLOR;
      else if (bx[k])     c[12*k +: 12] = X_COLOR;
      else if (bo[k])     c[12*k +: 12] = O_COLOR;
      else                c[12*k +: 12] = 12'h000;
    end
    return c;
  endfunction

  assign sq_mask     = 9'd1 << click_sq;
  assign mover_board = turn ? board_o : board_x;
  assign cur_line    = line_mask(line_idx);

  always_comb begin
    state_n    = state;
    board_x_n  = board_x;
    board_o_n  = board_o;
    win_line_n = win_line;
    line_idx_n = line_idx;
    turn_n     = turn;
    winner_n   = winner;
    move_cnt_n = move_cnt;
    if (~start_en | choice_en | new_game | (state == IDLE)) begin
      // Any clear: leaving the game screen, restart, or holding in IDLE.
      board_x_n  = '0;
      board_o_n  = '0;
      win_line_n = '0;
      line_idx_n = '0;
      turn_n     = FIRST_PLAYER;
      winner_n   = 2'b00;
      move_cnt_n = '0;
      state_n    = (~start_en | choice_en) ? IDLE : WAIT_CLICK;
    end else begin
      case (state)
        WAIT_CLICK: begin
          if (click && (click_sq <= 4'd8) && (((board_x | board_o) & sq_mask) == 9'd0)) begin
            if (turn) board_o_n = board_o | sq_mask;
            else      board_x_n = board_x | sq_mask;
            move_cnt_n = (move_cnt == 4'd9) ? 4'd9 : move_cnt + 4'd1;
            line_idx_n = '0;
            state_n    = CHECK;
          end
        end
        CHECK: begin
          if ((mover_board & cur_line) == cur_line) begin
            winner_n   = turn ? 2'b10 : 2'b01;
            win_line_n = cur_line;
            state_n    = OVER;
          end else if (line_idx == 3'd7) begin
            if (move_cnt == 4'd9) begin
              winner_n   = 2'b11;
              win_line_n = '0;
              state_n    = OVER;
            end else begin
              turn_n  = ~turn;
              state_n = WAIT_CLICK;
            end
          end else begin
            line_idx_n = line_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Colour is built from the next-state board so it lands on the same edge as square_en.
  assign color_n = color_mux(board_x_n, board_o_n, win_line_n, state_n == OVER);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      board_x      <= '0;
      board_o      <= '0;
      win_line     <= '0;
      line_idx     <= '0;
      turn         <= FIRST_PLAYER;
      winner       <= 2'b00;
      move_cnt     <= '0;
      square_color <= '0;
    end else begin
      state        <= state_n;
      board_x      <= board_x_n;
      board_o      <= board_o_n;
      win_line     <= win_line_n;
      line_idx     <= line_idx_n;
      turn         <= turn_n;
      winner       <= winner_n;
      move_cnt     <= move_cnt_n;
      square_color <= color_n;
    end
  end

  assign square_en = board_x | board_o;
  assign busy      = (state == CHECK);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_board_turn_ctrl.sv
// Bench for board_turn_ctrl: directed scenarios plus random games checked
// against a square-ownership model of tic-tac-toe.
module tb_board_turn_ctrl;

  localparam logic [11:0] XC = 12'hF00;
  localparam logic [11:0] OC = 12'h00F;
  localparam logic [11:0] WC = 12'h0F0;

  logic         pclk = 1'b0;
  logic         rst = 1'b1;
  logic         start_en = 1'b0;
  logic         choice_en = 1'b0;
  logic         click = 1'b0;
  logic [3:0]   click_sq = 4'd0;
  logic         new_game = 1'b0;
  logic [8:0]   square_en;
  logic [107:0] square_color;
  logic         turn;
  logic         busy;
  logic         game_over;
  logic [1:0]   winner;
  logic [3:0]   move_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: owner per square (0 empty, 1 X, 2 O)
  int         own [9];
  int         m_turn;
  int         m_moves;
  bit         m_over;
  int         m_winner;
  logic [8:0] m_wl;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  board_turn_ctrl dut (
    .pclk(pclk), .rst(rst), .start_en(start_en), .choice_en(choice_en),
    .click(click), .click_sq(click_sq), .new_game(new_game),
    .square_en(square_en), .square_color(square_color), .turn(turn),
    .busy(busy), .game_over(game_over), .winner(winner), .move_cnt(move_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [107:0] got, input logic [107:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) own[k] = 0;
    m_turn = 0; m_moves = 0; m_over = 0; m_winner = 0; m_wl = '0;
  endtask

  function automatic logic [8:0] exp_en();
    logic [8:0] e;
    for (int k = 0; k < 9; k++) e[k] = (own[k] != 0);
    return e;
  endfunction

  function automatic logic [107:0] exp_color();
    logic [107:0] c;
    c = '0;
    for (int k = 0; k < 9; k++) begin
      if (m_over && m_wl[k]) c[12*k +: 12] = WC;
      else if (own[k] == 1)  c[12*k +: 12] = XC;
      else if (own[k] == 2)  c[12*k +: 12] = OC;
    end
    return c;
  endfunction

  // Index of the first complete line owned by player p (1/2), or -1.
  function automatic int first_line(input int p);
    for (int l = 0; l < 8; l++)
      if (own[lines[l][0]] == p && own[lines[l][1]] == p && own[lines[l][2]] == p)
        return l;
    return -1;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".square_en"}, square_en, exp_en());
    chk({tag, ".color"}, square_color, exp_color());
    chk({tag, ".turn"}, turn, m_turn);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".game_over"}, game_over, m_over);
    chk({tag, ".winner"}, winner, m_winner);
    chk({tag, ".move_cnt"}, move_cnt, m_moves);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    chk_all("new_game");
  endtask

  // One click on square sq from the waiting/over state; follows the check to completion.
  task automatic play_click(input int sq);
    bit valid;
    int l;
    int c;
    int exp_lat;
    valid = !m_over && sq <= 8;
    if (valid) valid = (own[sq] == 0);
    click_sq = sq[3:0];
    click = 1'b1;
    tick();
    click = 1'b0;
    if (!valid) begin
      chk_all("ignored_click");
      return;
    end
    own[sq] = m_turn + 1;
    m_moves++;
    chk("click.square_en", square_en, exp_en());
    chk("click.busy", busy, 1);
    l = first_line(m_turn + 1);
    exp_lat = (l >= 0) ? 2 + l : 9;
    c = 1;
    while (busy === 1'b1 && c < 30) begin
      if ($urandom_range(0, 3) == 0) begin
        click_sq = 4'($urandom_range(0, 8));
        click = 1'b1;
      end
      tick();
      click = 1'b0;
      c++;
    end
    chk("check.latency", c, exp_lat);
    if (l >= 0) begin
      m_over = 1; m_winner = m_turn + 1; m_wl = '0;
      for (int j = 0; j < 3; j++) m_wl[lines[l][j]] = 1'b1;
    end else if (m_moves == 9) begin
      m_over = 1; m_winner = 3; m_wl = '0;
    end else begin
      m_turn = 1 - m_turn;
    end
    chk_all("after_check");
  endtask

  int seq_win  [5] = '{0, 3, 1, 4, 2};
  int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    model_clear();
    tick();
    tick();
    chk_all("reset");
    rst = 1'b0;
    tick();
    chk_all("idle_inactive");
    start_en = 1'b1;
    tick();
    chk_all("start");

    // X wins on the top row
    foreach (seq_win[i]) play_click(seq_win[i]);
    chk("win.winner", winner, 2'b01);
    chk("win.game_over", game_over, 1'b1);
    chk("win.sq0", square_color[11:0], WC);
    chk("win.sq2", square_color[35:24], WC);
    chk("win.sq3", square_color[47:36], OC);
    play_click(5);

    // Duplicate and out-of-range clicks
    do_new_game();
    play_click(4);
    play_click(4);
    play_click(9);
    chk("dup.move_cnt", move_cnt, 4'd1);
    chk("dup.turn", turn, 1'b1);

    // Full board with no winner
    do_new_game();
    foreach (seq_draw[i]) play_click(seq_draw[i]);
    chk("draw.winner", winner, 2'b11);
    chk("draw.square_en", square_en, 9'h1FF);

    // Leaving the game screen mid-check
    do_new_game();
    click_sq = 4'd0;
    click = 1'b1;
    tick();
    click = 1'b0;
    chk("abort.pre_busy", busy, 1'b1);
    choice_en = 1'b1;
    tick();
    model_clear();
    chk_all("abort");
    choice_en = 1'b0;
    tick();
    chk_all("abort_resume");

    // Random games
    for (int g = 0; g < 8; g++) begin
      int guard;
      do_new_game();
      guard = 0;
      while (!m_over && guard < 60) begin
        play_click($urandom_range(0, 9));
        guard++;
      end
      chk("rand.finished", m_over, 1'b1);
      play_click($urandom_range(0, 8));
    end

    // Asynchronous reset between clock edges
    do_new_game();
    play_click(4);
    play_click(0);
    @(posedge pclk);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    chk_all("async_rst");
    tick();
    rst = 1'b0;
    tick();
    play_click(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
